trace_emitter: RTL

TRACE_EMITTER -- requirements
Module: trace_emitter

---
 rtl/trace_pkg.sv | 45 ++++
 rtl/trace_emitter_if.sv | 16 +
 rtl/trace_fifo.sv | 42 ++++
 rtl/trace_emitter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the commit trace emitter: record kinds, serializer states and
// the FIFO entry layout. The cycle-stamp field exists only with TRACE_CYCLE_STAMP_EN.
package trace_pkg;

    typedef enum logic [1:0] {
        KIND_REG   = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_HALT  = 2'd3
    } recordKind_t;

    typedef enum logic [2:0] {
        IDLE,
        EMIT_REG,
        EMIT_LOAD,
        EMIT_STORE,
        EMIT_HALT,
        DONE
    } emitState_t;

    typedef struct packed {
        logic        regWr;
        logic        memRd;
        logic        memWr;
        logic [3:0]  wrReg;
        logic [15:0] wrData;
        logic [15:0] memAddr;
        logic [15:0] memRdata;
        logic [15:0] memWdata;
`ifdef TRACE_CYCLE_STAMP_EN
        logic [31:0] stamp;
`endif
    } commitEntry_t;

    localparam int ENTRY_W = $bits(commitEntry_t);

    // Next record of an entry after 'cur' (IDLE means "none emitted yet").
    function automatic emitState_t emitAfter(input emitState_t cur, input commitEntry_t e);
        if (cur == IDLE && e.regWr)                      return EMIT_REG;
        if ((cur == IDLE || cur == EMIT_REG) && e.memRd) return EMIT_LOAD;
        if (cur != EMIT_STORE && e.memWr)                return EMIT_STORE;
        return IDLE;
    endfunction

endpackage

// File: rtl/trace_emitter_if.sv
// Trace record stream: valid/ready handshake plus the record fields.
interface trace_emitter_if;
    import trace_pkg::*;

    logic        out_valid;
    logic        out_ready;
    recordKind_t out_kind;
    logic [15:0] out_addr;
    logic [15:0] out_data;
    logic [31:0] out_cycle;

    modport master (output out_valid, out_kind, out_addr, out_data, out_cycle,
                    input  out_ready);
    modport slave  (input  out_valid, out_kind, out_addr, out_data, out_cycle,
                    output out_ready);
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO of commit entries; head is visible combinationally on dout.
// A push while full is accepted only if a pop happens in the same cycle.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr, rdPtr;
    logic             wrEn;

    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign wrEn  = push && (!full || pop);
    assign dout  = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (wrEn)          wrPtr <= wrPtr + (AW+1)'(1);
            if (pop && !empty) rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wrEn) mem[wrPtr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/trace_emitter.sv
// Commit trace emitter: queues per-cycle commit entries and serializes them into
// REG/LOAD/STORE records, closing with one HALT record. Option: TRACE_CYCLE_STAMP_EN.
module trace_emitter
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   reg_write,
    input  logic [3:0]             wr_reg,
    input  logic [15:0]            wr_data,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [15:0]            mem_addr,
    input  logic [15:0]            mem_rdata,
    input  logic [15:0]            mem_wdata,
    input  logic                   halt,
    trace_emitter_if.master        traceOut,
    output logic [31:0]            inst_count,
    output logic [31:0]            cycle_count,
    output logic                   overflow,
    output logic                   done
);
    emitState_t         state, nextState, following;
    commitEntry_t       pushEntry, head;
    logic [ENTRY_W-1:0] headBits;
    logic               haltSeen, commitReq, fifoPop, fifoFull, fifoEmpty;

    assign commitReq = !haltSeen && (reg_write || mem_read || mem_write);
    assign head      = commitEntry_t'(headBits);
    assign done      = (state == DONE);

    always_comb begin
        pushEntry          = '0;
        pushEntry.regWr    = reg_write;
        pushEntry.memRd    = mem_read;
        pushEntry.memWr    = mem_write;
        pushEntry.wrReg    = wr_reg;
        pushEntry.wrData   = wr_data;
        pushEntry.memAddr  = mem_addr;
        pushEntry.memRdata = mem_rdata;
        pushEntry.memWdata = mem_wdata;
`ifdef TRACE_CYCLE_STAMP_EN
        pushEntry.stamp    = cycle_count;
`endif
    end

    // The head entry stays in the FIFO until its last record is transferred.
    trace_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (commitReq),
        .pop   (fifoPop),
        .din   (pushEntry),
        .dout  (headBits),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            haltSeen    <= 1'b0;
            inst_count  <= '0;
            cycle_count <= '0;
            overflow    <= 1'b0;
        end else if (!haltSeen) begin
            cycle_count <= cycle_count + 32'd1;
            if (halt || reg_write || mem_write) inst_count <= inst_count + 32'd1;
            if (halt) haltSeen <= 1'b1;
            if (commitReq && fifoFull && !fifoPop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        nextState          = state;
        following          = emitAfter(state, head);
        fifoPop            = 1'b0;
        traceOut.out_valid = 1'b0;
        traceOut.out_kind  = KIND_REG;
        traceOut.out_addr  = '0;
        traceOut.out_data  = '0;
        traceOut.out_cycle = '0;
        case (state)
            IDLE: begin
                if (!fifoEmpty)    nextState = emitAfter(IDLE, head);
                else if (haltSeen) nextState = EMIT_HALT;
            end
            EMIT_REG, EMIT_LOAD, EMIT_STORE: begin
                traceOut.out_valid = 1'b1;
                if (state == EMIT_REG) begin
                    traceOut.out_kind = KIND_REG;
                    traceOut.out_addr = {12'h000, head.wrReg};
                    traceOut.out_data = head.wrData;
                end else if (state == EMIT_LOAD) begin
                    traceOut.out_kind = KIND_LOAD;
                    traceOut.out_addr = head.memAddr;
                    traceOut.out_data = head.memRdata;
                end else begin
                    traceOut.out_kind = KIND_STORE;
                    traceOut.out_addr = head.memAddr;
                    traceOut.out_data = head.memWdata;
                end
`ifdef TRACE_CYCLE_STAMP_EN
                traceOut.out_cycle = head.stamp;
`endif
                if (traceOut.out_ready) begin
                    nextState = following;
                    fifoPop   = (following == IDLE);
                end
            end
            EMIT_HALT: begin
                traceOut.out_valid = 1'b1;
                traceOut.out_kind  = KIND_HALT;
                traceOut.out_data  = inst_count[15:0];
`ifdef TRACE_CYCLE_STAMP_EN
                traceOut.out_cycle = cycle_count;
`endif
                if (traceOut.out_ready) nextState = DONE;
            end
            DONE:    nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

endmodule
